// File: rtl/ifmap_fetch_scheduler_pkg.sv
// Shared types and geometry for the ifmap fetch scheduler: FSM states,
// image/kernel defaults and the counter widths derived from them.
package ifmap_pkg;

    localparam int IMG_W          = 32;
    localparam int IMG_H          = 32;
    localparam int K              = 5;
    localparam int ROUNDS         = IMG_H - K + 1;
    localparam int DATA_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 10;
    localparam int STARVE_LIM_DEF = 8;

    localparam int COL_W   = $clog2(IMG_W);
    localparam int SLOT_W  = 3;
    localparam int ROW_W   = $clog2(IMG_H + 1);
    localparam int ROUND_W = $clog2(ROUNDS + 1);
    localparam int ISSUE_W = $clog2(K * IMG_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT,
        ST_FETCH_ROW,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/ifmap_fetch_scheduler_sram_port_arbiter.sv
// Single-port SRAM arbiter: fetch engine wins by default, the host is forced
// a grant after STARVE_LIM consecutive denied cycles.
module sram_port_arbiter
    import ifmap_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_want,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              fetch_go,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_cnt;

    // A forced host grant simply suppresses this cycle's fetch; the fetch
    // counters do not advance, so the beat is retried next cycle.
    assign host_gnt   = host_req && (!fetch_want || starve_cnt == CNT_W'(STARVE_LIM));
    assign fetch_go   = fetch_want && !host_gnt;
    assign sram_en    = host_gnt || fetch_go;
    assign sram_we    = host_gnt && host_we;
    assign sram_addr  = host_gnt ? host_addr : (fetch_go ? fetch_addr : '0);
    assign sram_wdata = host_gnt ? host_wdata : '0;

    // NOTE: sequential state uses <= so every register samples pre-edge values
    // regardless of statement order inside the block.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_gnt && !host_we;
            if (host_req && !host_gnt)
                starve_cnt <= starve_cnt + CNT_W'(1);
            else
                starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/ifmap_fetch_scheduler.sv
// Ifmap fetch scheduler: primes K rows into the window buffer, then slides one
// row per mapping round. Optional stall counter under FETCH_PERF_CNT_EN.
module ifmap_fetch_scheduler
    import ifmap_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] ifmap_base,
    input  logic              round_done,
    input  logic              buf_ready,
    output logic              busy,
    output logic              done,
    output logic              rows_ready,
    output logic              buf_wr_en,
    output logic [SLOT_W-1:0] buf_wr_slot,
    output logic [COL_W-1:0]  buf_wr_col,
    output logic [DATA_W-1:0] buf_wr_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       stall_cycles,
`endif
    input  logic [DATA_W-1:0] sram_rdata
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [ROUND_W-1:0]  round_q;
    logic [ISSUE_W-1:0]  issue_rem_q;
    logic                pending_q;
    logic                rd_valid_q;
    logic [SLOT_W-1:0]   rd_slot_q;
    logic [COL_W-1:0]    rd_col_q;

    logic                start_ok, fetch_phase, fetch_want, fetch_go, win_done, wait_adv;
    logic [ROUND_W-1:0]  round_next;
    logic [ADDR_W-1:0]   fetch_addr;

    assign start_ok    = (state_q == ST_IDLE) && start;
    assign fetch_phase = (state_q == ST_PRIME) || (state_q == ST_FETCH_ROW);
    assign fetch_want  = fetch_phase && buf_ready && (issue_rem_q != '0);
    // A window is complete once every beat is issued and the last read has landed.
    assign win_done    = fetch_phase && (issue_rem_q == '0) && !rd_valid_q;
    assign wait_adv    = (state_q == ST_WAIT) && (round_done || pending_q);
    assign round_next  = round_q + ROUND_W'(1);
    assign fetch_addr  = base_q + ADDR_W'(int'(row_q) * IMG_W + int'(col_q));

    sram_port_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk         (clk),
        .nrst        (nrst),
        .fetch_want  (fetch_want),
        .fetch_addr  (fetch_addr),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .fetch_go    (fetch_go),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata)
    );

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:                if (start) state_d = ST_PRIME;
            ST_PRIME, ST_FETCH_ROW: if (win_done) state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_adv) begin
                    if (round_next == ROUND_W'(ROUNDS))
                        state_d = ST_FINISH;
                    else if (row_q < ROW_W'(IMG_H))
                        state_d = ST_FETCH_ROW;
                end
            end
            ST_FINISH:              state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            slot_q      <= '0;
            round_q     <= '0;
            issue_rem_q <= '0;
            pending_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_slot_q   <= '0;
            rd_col_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= fetch_go;
            if (start_ok) begin
                base_q      <= ifmap_base;
                row_q       <= '0;
                col_q       <= '0;
                slot_q      <= '0;
                round_q     <= '0;
                pending_q   <= 1'b0;
                issue_rem_q <= ISSUE_W'(K * IMG_W);
            end
            if (fetch_go) begin
                rd_slot_q   <= slot_q;
                rd_col_q    <= col_q;
                issue_rem_q <= issue_rem_q - ISSUE_W'(1);
                if (col_q == COL_W'(IMG_W - 1)) begin
                    col_q  <= '0;
                    row_q  <= row_q + ROW_W'(1);
                    slot_q <= (slot_q == SLOT_W'(K - 1)) ? '0 : slot_q + SLOT_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            // A round finishing while the next row is still streaming is remembered.
            if (state_q == ST_FETCH_ROW && round_done)
                pending_q <= 1'b1;
            if (wait_adv) begin
                round_q   <= round_next;
                pending_q <= 1'b0;
            end
            if (state_q == ST_WAIT && state_d == ST_FETCH_ROW)
                issue_rem_q <= ISSUE_W'(IMG_W);
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign rows_ready  = win_done;
    assign buf_wr_en   = rd_valid_q;
    assign buf_wr_slot = rd_slot_q;
    assign buf_wr_col  = rd_col_q;
    assign buf_wr_data = rd_valid_q ? sram_rdata : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            stall_cycles <= '0;
        else if (start_ok)
            stall_cycles <= '0;
        else if (fetch_phase && issue_rem_q != '0 && (!buf_ready || host_gnt)
                 && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ifmap_fetch_scheduler.sv
// Directed bench for ifmap_fetch_scheduler: prime, sliding rounds, host
// starvation grant, buf_ready stalls, pending round, async reset and restart.
module tb_ifmap_fetch_scheduler;

    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] ifmap_base = '0;
    logic          round_done = 1'b0;
    logic          buf_ready = 1'b0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          busy, done, rows_ready, buf_wr_en;
    logic [2:0]    buf_wr_slot;
    logic [4:0]    buf_wr_col;
    logic [DW-1:0] buf_wr_data;
    logic          host_gnt, host_rvalid, sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] mem [0:1023];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [15:0]   wq[$];
    int            wcyc[$];
    int            rr_cnt = 0, rr_cyc = 0, rr_last_wr = 0, last_wr_cyc = 0, done_cnt = 0;

    ifmap_fetch_scheduler dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .ifmap_base  (ifmap_base),
        .round_done  (round_done),
        .buf_ready   (buf_ready),
        .busy        (busy),
        .done        (done),
        .rows_ready  (rows_ready),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_slot (buf_wr_slot),
        .buf_wr_col  (buf_wr_col),
        .buf_wr_data (buf_wr_data),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-only SRAM model with one cycle of latency.
    always @(posedge clk)
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];

    always @(negedge clk) begin
        if (buf_wr_en) begin
            wq.push_back({buf_wr_slot, buf_wr_col, buf_wr_data});
            wcyc.push_back(cyc);
            last_wr_cyc <= cyc;
        end
        if (rows_ready) begin
            rr_cnt     <= rr_cnt + 1;
            rr_cyc     <= cyc;
            rr_last_wr <= last_wr_cyc;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, rows_ready, buf_wr_en, buf_wr_slot, buf_wr_col, buf_wr_data,
                    host_gnt, host_rvalid, sram_en, sram_we, sram_addr, sram_wdata});
    endfunction

    // Write k of a frame lands in row k/32, slot (k/32) mod 5, column k mod 32.
    function automatic logic [15:0] exp_wr(input int base, input int k);
        int r;
        r = k / 32;
        return {3'(r % 5), 5'(k % 32), mem[(base + k) % 1024]};
    endfunction

    task automatic check_writes(input string tag, input int base, input int first_k,
                                input int q_first, input int n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, first_k + i), 64'(wq[q_first + i]),
                64'(exp_wr(base, first_k + i)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, gnt_at, q0, tgt, prev_rr;
        bit skip;

        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + (i >> 5)) & 255);

        #1 nrst = 1'b0;
        #2 chk("reset_outs", outs(), 64'(0));
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        tick();
        chk("idle_after_reset", outs(), 64'(0));

        // Frame 1: base 0, no host at first.
        buf_ready  = 1'b1;
        ifmap_base = 10'h000;
        start      = 1'b1;
        c0         = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int i = 0; i < 10 && wq.size() == 0; i++) tick();
        chk("first_wr_cycle", 64'(wcyc[0]), 64'(c0 + 2));

        // round_done during PRIME must not count as a round.
        round_done = 1'b1;
        tick();
        round_done = 1'b0;

        // Host read held during PRIME: granted on its 9th waiting cycle.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 10'h3F0;
        #1;
        gnt_at = 0;
        for (int i = 1; i <= 20 && gnt_at == 0; i++) begin
            if (host_gnt) gnt_at = i;
            else tick();
        end
        chk("host_gnt_cycle", 64'(gnt_at), 64'(9));
        chk("host_gnt_addr", 64'(sram_addr), 64'(10'h3F0));
        chk("host_gnt_we", 64'(sram_we), 64'(0));
        tick();
        chk("host_rvalid", 64'(host_rvalid), 64'(1));
        chk("fetch_deferred", 64'(buf_wr_en), 64'(0));
        host_req = 1'b0;
        tick();
        chk("host_rvalid_pulse", 64'(host_rvalid), 64'(0));

        for (int i = 0; i < 300 && rr_cnt < 1; i++) tick();
        chk("prime_rows_ready", 64'(rr_cnt), 64'(1));
        chk("prime_writes", 64'(wq.size()), 64'(160));
        chk("prime_rr_timing", 64'(rr_cyc - rr_last_wr), 64'(1));
        check_writes("prime_wr", 0, 0, 0, 160);

        repeat (3) tick();
        chk("wait_quiet", 64'({buf_wr_en, sram_en}), 64'(0));
        start      = 1'b1;
        ifmap_base = 10'h200;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("start_ignored_busy", 64'(busy), 64'(1));
        chk("start_ignored_wq", 64'(wq.size()), 64'(160));

        // 27 sliding rounds; round 3 toggles buf_ready, round 5 leaves a
        // pending round_done that launches round 6 without a new pulse.
        skip    = 1'b0;
        prev_rr = 0;
        for (int n = 0; n < 27; n++) begin
            q0  = wq.size();
            tgt = rr_cnt + 1;
            if (!skip) begin
                round_done = 1'b1;
                tick();
                round_done = 1'b0;
            end
            skip = 1'b0;
            for (int i = 0; i < 200 && rr_cnt < tgt; i++) begin
                if (n == 3) buf_ready = ~buf_ready;
                if (n == 5 && i == 10) round_done = 1'b1;
                if (n == 5 && i == 11) round_done = 1'b0;
                if (n == 7 && i == 10) begin
                    start      = 1'b1;
                    ifmap_base = 10'h200;
                end
                if (n == 7 && i == 11) start = 1'b0;
                tick();
            end
            buf_ready = 1'b1;
            chk($sformatf("round%0d_rows_ready", n), 64'(rr_cnt), 64'(tgt));
            chk($sformatf("round%0d_writes", n), 64'(wq.size() - q0), 64'(32));
            chk($sformatf("round%0d_rr_timing", n), 64'(rr_cyc - rr_last_wr), 64'(1));
            check_writes($sformatf("round%0d_wr", n), 0, 160 + 32 * n, q0, 32);
            if (n == 6) chk("pending_no_gap", 64'(wcyc[q0]), 64'(prev_rr + 3));
            prev_rr = rr_cyc;
            if (n == 5) skip = 1'b1;
            else repeat (3) tick();
        end

        // 28th round completes the frame.
        round_done = 1'b1;
        tick();
        round_done = 1'b0;
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_in_finish", 64'(busy), 64'(1));
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_after_done", 64'(busy), 64'(0));
        chk("frame_writes", 64'(wq.size()), 64'(1024));
        chk("done_count", 64'(done_cnt), 64'(1));

        // Frame 2 wraps the address space, then is cut by reset at write 70.
        wq.delete();
        wcyc.delete();
        ifmap_base = 10'h3C0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && wq.size() < 70; i++) tick();
        chk("reached_write_70", 64'(wq.size()), 64'(70));
        nrst = 1'b0;
        #1;
        chk("async_reset_outs", outs(), 64'(0));
        check_writes("wrap_wr", 10'h3C0, 0, 0, 70);
        repeat (2) tick();
        chk("no_write_in_reset", 64'(wq.size()), 64'(70));
        nrst = 1'b1;
        tick();

        // Frame 3 restarts cleanly from base 0x100.
        wq.delete();
        wcyc.delete();
        tgt        = rr_cnt + 1;
        ifmap_base = 10'h100;
        start      = 1'b1;
        c0         = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && rr_cnt < tgt; i++) tick();
        chk("restart_rows_ready", 64'(rr_cnt), 64'(tgt));
        chk("restart_writes", 64'(wq.size()), 64'(160));
        chk("restart_first_wr", 64'(wcyc[0]), 64'(c0 + 2));
        check_writes("restart_wr", 10'h100, 0, 0, 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
